// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice built from two half adders is
// time-shared over WIDTH cycles, LSB first, behind a start/busy/done handshake.

module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] op_a, op_b, sum_r;
    logic             carry, cout_r;
    logic [CW-1:0]    cnt;
    logic             s1, c1, s, c2, co, last;

    halfadder u_ha1 (.a(op_a[0]), .b(op_b[0]), .s(s1), .c(c1));
    halfadder u_ha2 (.a(s1),      .b(carry),   .s(s),  .c(c2));

    assign co   = c1 | c2;
    assign last = (cnt == LAST);
    assign sum  = sum_r;
    assign cout = cout_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 lands at sum[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r <= {s, sum_r[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (last) cout_r <= co;
                end
                default: ;
            endcase
        end
    end
endmodule
